// File: rtl/bridge_tx_queued.sv
// Response FIFO feeding an ASCII frame engine toward a UART TX byte port.
// Read frames are 'M', hex nibbles MSB-first, CR, LF; write acknowledgements are 'M', CR, LF.
module bridge_tx_queued #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4,
  parameter bit WRITE_ACK  = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic                  rw_i,
  input  logic                  valid_i,
  output logic [7:0]            data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  full_o,
  output logic                  overflow_o
);
  localparam int NIBBLES = DATA_WIDTH / 4;
  localparam int IDX_W   = $clog2(NIBBLES + 3);
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(DEPTH);
  localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_ACK_LF = IDX_W'(2);
  localparam logic [IDX_W-1:0] IDX_CR     = IDX_W'(NIBBLES + 1);
  localparam logic [IDX_W-1:0] IDX_LF     = IDX_W'(NIBBLES + 2);

  typedef enum logic {IDLE, SEND} state_t;

  // Each entry is {is_ack, data}
  logic [DATA_WIDTH:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  full_q, full_d, overflow_q, overflow_d;
  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] frame_q, frame_d;
  logic                  is_ack_q, is_ack_d;

  logic                  push_req, push_ok, pop, fifo_empty, last_byte;
  logic [DATA_WIDTH:0]   head;
  logic [3:0]            nib_w [NIBBLES];
  logic [3:0]            nib_sel;

  assign head       = mem_q[rd_ptr_q];
  assign fifo_empty = (count_q == '0);
  assign push_req   = valid_i && (!rw_i || WRITE_ACK);
  // full_q reflects the count before this edge, so a same-edge pop cannot rescue a push
  assign push_ok    = push_req && !full_q;
  assign last_byte  = is_ack_q ? (idx_q == IDX_ACK_LF) : (idx_q == IDX_LF);
  assign pop        = !fifo_empty && ((state_q == IDLE) || (ready_i && last_byte));

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= {rw_i, rdata_i};
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push_ok) count_d = count_q - 1'b1;
    full_d     = (count_d == CNT_FULL);
    overflow_d = overflow_q || (push_req && full_q);
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    frame_d  = frame_q;
    is_ack_d = is_ack_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d  = SEND;
          idx_d    = '0;
          frame_d  = head[DATA_WIDTH-1:0];
          is_ack_d = head[DATA_WIDTH];
        end
      end
      SEND: begin
        if (ready_i) begin
          if (!last_byte) begin
            idx_d = idx_q + 1'b1;
          end else if (!fifo_empty) begin
            idx_d    = '0;
            frame_d  = head[DATA_WIDTH-1:0];
            is_ack_d = head[DATA_WIDTH];
          end else begin
            idx_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
    assign nib_w[gi] = frame_q[DATA_WIDTH - 4*gi - 1 -: 4];
  end

  always_comb begin
    nib_sel = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == IDX_W'(i + 1)) nib_sel = nib_w[i];
    end
  end

  always_comb begin
    valid_o = (state_q == SEND);
    data_o  = 8'h00;
    if (state_q == SEND) begin
      if (idx_q == '0)            data_o = 8'h4D;
      else if (is_ack_q)          data_o = (idx_q == IDX_ONE) ? 8'h0D : 8'h0A;
      else if (idx_q == IDX_CR)   data_o = 8'h0D;
      else if (idx_q == IDX_LF)   data_o = 8'h0A;
      else if (nib_sel < 4'd10)   data_o = 8'h30 + {4'h0, nib_sel};
      else                        data_o = 8'h37 + {4'h0, nib_sel};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      state_q    <= IDLE;
      idx_q      <= '0;
      frame_q    <= '0;
      is_ack_q   <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      idx_q      <= idx_d;
      frame_q    <= frame_d;
      is_ack_q   <= is_ack_d;
    end
  end

  assign full_o     = full_q;
  assign overflow_o = overflow_q;
endmodule

// File: tb/tb_bridge_tx_queued.sv
// Two instances (16-bit with write acks, 32-bit without) share one stimulus stream;
// a queue-based byte-stream model predicts every output each cycle.
module tb_bridge_tx_queued;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0;
  logic        rw_i = 1'b0;
  logic        ready_i = 1'b0;
  logic [31:0] rdata = '0;
  logic [7:0]  a_data, b_data;
  logic        a_valid, b_valid, a_full, b_full, a_ovf, b_ovf;

  int checks = 0;
  int errors = 0;

  bridge_tx_queued #(.DATA_WIDTH(16), .DEPTH(DEPTH), .WRITE_ACK(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .rdata_i(rdata[15:0]), .rw_i(rw_i), .valid_i(valid_i),
    .data_o(a_data), .valid_o(a_valid), .ready_i(ready_i), .full_o(a_full), .overflow_o(a_ovf));

  bridge_tx_queued #(.DATA_WIDTH(32), .DEPTH(DEPTH), .WRITE_ACK(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .rdata_i(rdata), .rw_i(rw_i), .valid_i(valid_i),
    .data_o(b_data), .valid_o(b_valid), .ready_i(ready_i), .full_o(b_full), .overflow_o(b_ovf));

  // Reference model: pending entries, remaining bytes of the frame on the wire, sticky drop flag
  logic [32:0] fq [2][$];
  logic [7:0]  bq [2][$];
  bit          ov [2];
  int          nib_of [2] = '{4, 8};
  bit          wa_of  [2] = '{1'b1, 1'b0};

  function automatic logic [7:0] frame_byte(input bit ack, input logic [31:0] d, input int nib, input int i);
    logic [3:0] n;
    if (i == 0) return 8'h4D;
    if (ack) return (i == 1) ? 8'h0D : 8'h0A;
    if (i <= nib) begin
      n = 4'((d >> (4 * (nib - i))) & 32'hF);
      return (n < 4'd10) ? 8'h30 + 8'(n) : 8'h41 + 8'(n) - 8'd10;
    end
    return (i == nib + 1) ? 8'h0D : 8'h0A;
  endfunction

  task automatic model_load(input int m);
    logic [32:0] e;
    int len;
    e = fq[m].pop_front();
    len = e[32] ? 3 : nib_of[m] + 3;
    for (int i = 0; i < len; i++) bq[m].push_back(frame_byte(e[32], e[31:0], nib_of[m], i));
  endtask

  task automatic model_edge(input int m);
    int pre;
    logic [31:0] d;
    if (!rst_n) begin
      fq[m].delete();
      bq[m].delete();
      ov[m] = 1'b0;
      return;
    end
    pre = fq[m].size();
    if (bq[m].size() > 0) begin
      if (ready_i) begin
        void'(bq[m].pop_front());
        if (bq[m].size() == 0 && pre > 0) model_load(m);
      end
    end else if (pre > 0) begin
      model_load(m);
    end
    if (valid_i && (!rw_i || wa_of[m])) begin
      d = (m == 0) ? {16'h0, rdata[15:0]} : rdata;
      if (pre == DEPTH) ov[m] = 1'b1;
      else fq[m].push_back({rw_i, d});
    end
  endtask

  logic [10:0] mon_obs, mon_exp;
  logic        mon_v;
  logic [7:0]  mon_d;
  always begin
    @(posedge clk);
    for (int m = 0; m < 2; m++) model_edge(m);
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      mon_obs = (m == 0) ? {a_valid, a_data, a_full, a_ovf} : {b_valid, b_data, b_full, b_ovf};
      mon_v = (bq[m].size() > 0);
      mon_d = mon_v ? bq[m][0] : 8'h00;
      mon_exp = {mon_v, mon_d, (fq[m].size() == DEPTH), ov[m]};
      checks++;
      if (mon_obs !== mon_exp) begin
        errors++;
        $display("FAIL stream dut%0d t=%0t got v/d/full/ovf=%b/%h/%b/%b expected %b/%h/%b/%b", m, $time,
                 mon_obs[10], mon_obs[9:2], mon_obs[1], mon_obs[0],
                 mon_exp[10], mon_exp[9:2], mon_exp[1], mon_exp[0]);
      end
    end
  end

  typedef struct packed { logic v; logic rw; logic [31:0] d; } stim_t;
  stim_t       stim_q[$];
  logic [7:0]  cap_a[$], cap_b[$];
  bit          va_hist[$], fa_hist[$], oa_hist[$];
  int          hold_viol;

  task automatic clear_caps();
    cap_a.delete(); cap_b.delete();
    va_hist.delete(); fa_hist.delete(); oa_hist.delete();
    hold_viol = 0;
  endtask

  // mode: 0 ready high, 1 ready pattern 1,0,0, 2 ready low, 3 random ready
  task automatic run(input int cycles, input int mode, input int stop_b);
    stim_t s;
    logic [7:0] prev_d;
    bit prev_hold;
    prev_hold = 1'b0;
    prev_d = 8'h00;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (prev_hold && a_data !== prev_d) hold_viol++;
      if (stim_q.size() > 0) begin
        s = stim_q.pop_front();
        valid_i = s.v; rw_i = s.rw; rdata = s.d;
      end else begin
        valid_i = 1'b0; rw_i = 1'b0; rdata = '0;
      end
      case (mode)
        0: ready_i = 1'b1;
        1: ready_i = (c % 3 == 0);
        2: ready_i = 1'b0;
        default: ready_i = 1'($urandom_range(0, 1));
      endcase
      va_hist.push_back(a_valid); fa_hist.push_back(a_full); oa_hist.push_back(a_ovf);
      prev_hold = a_valid && !ready_i;
      prev_d = a_data;
      if (a_valid && ready_i) cap_a.push_back(a_data);
      if (b_valid && ready_i) cap_b.push_back(b_data);
      if (stop_b > 0 && cap_b.size() >= stop_b) break;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({a_valid, a_data, a_full, a_ovf, b_valid, b_data, b_full, b_ovf} !== 22'h0) begin
      errors++;
      $display("FAIL reset got a=%b/%h/%b/%b b=%b/%h/%b/%b expected all zero",
               a_valid, a_data, a_full, a_ovf, b_valid, b_data, b_full, b_ovf);
    end
    rst_n = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_single_read();
    logic [7:0] exp_b [7] = '{8'h4D, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};
    int first, last, ones;
    clear_caps();
    stim_q.push_back({1'b1, 1'b0, 32'h0000BEEF});
    run(20, 0, 0);
    checks++;
    if (cap_a.size() != 7) begin errors++; $display("FAIL single_len got %0d expected 7", cap_a.size()); end
    for (int i = 0; i < 7 && i < cap_a.size(); i++) begin
      checks++;
      if (cap_a[i] !== exp_b[i]) begin errors++; $display("FAIL single_byte%0d got %h expected %h", i, cap_a[i], exp_b[i]); end
    end
    first = -1; last = -1; ones = 0;
    foreach (va_hist[i]) begin
      if (va_hist[i]) begin if (first < 0) first = i; last = i; ones++; end
    end
    checks++;
    if (first != 2) begin errors++; $display("FAIL single_latency got first valid cycle %0d expected 2", first); end
    checks++;
    if (ones != 7 || last - first + 1 != 7) begin
      errors++; $display("FAIL single_contig got %0d valid cycles span %0d expected 7", ones, last - first + 1);
    end
    $display("test_single_read bytes=%0d", cap_a.size());
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_b [7] = '{8'h4D, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};
    clear_caps();
    stim_q.push_back({1'b1, 1'b0, 32'h0000BEEF});
    run(60, 1, 0);
    checks++;
    if (cap_a.size() != 7) begin errors++; $display("FAIL bp_len got %0d expected 7", cap_a.size()); end
    for (int i = 0; i < 7 && i < cap_a.size(); i++) begin
      checks++;
      if (cap_a[i] !== exp_b[i]) begin errors++; $display("FAIL bp_byte%0d got %h expected %h", i, cap_a[i], exp_b[i]); end
    end
    checks++;
    if (hold_viol != 0) begin errors++; $display("FAIL bp_hold got %0d changes while stalled expected 0", hold_viol); end
    checks++;
    if (cap_b.size() != 11) begin errors++; $display("FAIL bp_len32 got %0d expected 11", cap_b.size()); end
    $display("test_backpressure bytes=%0d", cap_a.size());
  endtask

  task automatic test_back_to_back();
    logic [7:0] mid [7] = '{8'h4D, 8'h30, 8'h30, 8'h41, 8'h30, 8'h0D, 8'h0A};
    int first, last, ones;
    clear_caps();
    stim_q.push_back({1'b1, 1'b0, 32'h00000001});
    stim_q.push_back({1'b1, 1'b0, 32'h000000A0});
    stim_q.push_back({1'b1, 1'b0, 32'h0000FFFF});
    run(50, 0, 0);
    checks++;
    if (cap_a.size() != 21) begin errors++; $display("FAIL b2b_len got %0d expected 21", cap_a.size()); end
    for (int i = 0; i < 7 && i + 7 < cap_a.size(); i++) begin
      checks++;
      if (cap_a[i + 7] !== mid[i]) begin errors++; $display("FAIL b2b_mid%0d got %h expected %h", i, cap_a[i + 7], mid[i]); end
    end
    first = -1; last = -1; ones = 0;
    foreach (va_hist[i]) begin
      if (va_hist[i]) begin if (first < 0) first = i; last = i; ones++; end
    end
    checks++;
    if (ones != 21 || last - first + 1 != 21) begin
      errors++; $display("FAIL b2b_contig got %0d valid cycles span %0d expected 21", ones, last - first + 1);
    end
    $display("test_back_to_back bytes=%0d", cap_a.size());
  endtask

  task automatic test_overflow();
    int lf;
    clear_caps();
    for (int k = 0; k < 6; k++) stim_q.push_back({1'b1, 1'b0, 32'h1111 * (k + 1)});
    run(8, 2, 0);
    checks++;
    if (fa_hist[4] !== 1'b0 || fa_hist[5] !== 1'b1) begin
      errors++; $display("FAIL ovf_full got %b%b expected 01 around fifth read", fa_hist[4], fa_hist[5]);
    end
    checks++;
    if (oa_hist[5] !== 1'b0 || oa_hist[6] !== 1'b1) begin
      errors++; $display("FAIL ovf_flag got %b%b expected 01 around sixth read", oa_hist[5], oa_hist[6]);
    end
    run(80, 0, 0);
    lf = 0;
    foreach (cap_a[i]) if (cap_a[i] == 8'h0A) lf++;
    checks++;
    if (lf != 5 || cap_a.size() != 35) begin
      errors++; $display("FAIL ovf_frames got %0d frames %0d bytes expected 5 frames 35 bytes", lf, cap_a.size());
    end
    checks++;
    if (cap_b.size() != 55) begin errors++; $display("FAIL ovf_frames32 got %0d bytes expected 55", cap_b.size()); end
    checks++;
    if (a_ovf !== 1'b1 || a_full !== 1'b0) begin
      errors++; $display("FAIL ovf_sticky got ovf=%b full=%b expected ovf=1 full=0", a_ovf, a_full);
    end
    $display("test_overflow frames=%0d", lf);
  endtask

  task automatic test_write_ack();
    logic [7:0] exp_b [10] = '{8'h4D, 8'h0D, 8'h0A, 8'h4D, 8'h31, 8'h32, 8'h33, 8'h34, 8'h0D, 8'h0A};
    clear_caps();
    stim_q.push_back({1'b1, 1'b1, 32'hCAFE5555});
    stim_q.push_back({1'b1, 1'b0, 32'h00001234});
    run(50, 0, 0);
    checks++;
    if (cap_a.size() != 10) begin errors++; $display("FAIL ack_len got %0d expected 10", cap_a.size()); end
    for (int i = 0; i < 10 && i < cap_a.size(); i++) begin
      checks++;
      if (cap_a[i] !== exp_b[i]) begin errors++; $display("FAIL ack_byte%0d got %h expected %h", i, cap_a[i], exp_b[i]); end
    end
    checks++;
    if (cap_b.size() != 11) begin errors++; $display("FAIL noack_len got %0d expected 11", cap_b.size()); end
    $display("test_write_ack bytes=%0d/%0d", cap_a.size(), cap_b.size());
  endtask

  task automatic test_wide_reset();
    logic [7:0] exp_b [3] = '{8'h4D, 8'h44, 8'h45};
    clear_caps();
    stim_q.push_back({1'b1, 1'b0, 32'hDEADBEEF});
    run(30, 0, 3);
    checks++;
    if (cap_b.size() != 3) begin errors++; $display("FAIL wide_len got %0d expected 3", cap_b.size()); end
    for (int i = 0; i < 3 && i < cap_b.size(); i++) begin
      checks++;
      if (cap_b[i] !== exp_b[i]) begin errors++; $display("FAIL wide_byte%0d got %h expected %h", i, cap_b[i], exp_b[i]); end
    end
    @(negedge clk);
    ready_i = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({b_valid, b_data, b_full, b_ovf, a_valid, a_ovf} !== 13'h0) begin
      errors++; $display("FAIL wide_abort got b=%b/%h/%b/%b a=%b/%b expected all zero",
                         b_valid, b_data, b_full, b_ovf, a_valid, a_ovf);
    end
    rst_n = 1'b1;
    clear_caps();
    run(12, 0, 0);
    checks++;
    if (cap_a.size() != 0 || cap_b.size() != 0) begin
      errors++; $display("FAIL wide_empty got %0d/%0d bytes after reset expected 0/0", cap_a.size(), cap_b.size());
    end
    $display("test_wide_reset done");
  endtask

  task automatic test_random();
    clear_caps();
    for (int k = 0; k < 400; k++)
      stim_q.push_back({1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 1)), 32'($urandom)});
    run(400, 3, 0);
    run(300, 0, 0);
    checks++;
    if (a_valid !== 1'b0 || b_valid !== 1'b0) begin
      errors++; $display("FAIL rand_drain got valid a=%b b=%b expected 0/0", a_valid, b_valid);
    end
    $display("test_random bytes=%0d/%0d", cap_a.size(), cap_b.size());
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_write_ack();
    test_wide_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bridge_tx_queued.md
Name: bridge_tx_queued

Overview:
- Parametrised successor of the bus-to-UART response formatter. Turns bus read responses into ASCII frames for the UART transmitter: preamble 'M', hex digits MSB-first, CR, LF.
- Adds a generic data width and a response FIFO, so back-to-back reads are not lost while a frame is in flight.
- Optional write acknowledgements. Sits between the bus core's response port and the UART TX byte interface.

Parameters:
- DATA_WIDTH, 16, response data width. Must be a multiple of 4, range 4..64. NIBBLES = DATA_WIDTH/4.
- DEPTH, 4, response FIFO entries. Power of two, at least 2.
- WRITE_ACK, 0, when 1 a write transaction queues an acknowledge frame "M\r\n".

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- rdata_i  in  DATA_WIDTH  read data from bus core
- rw_i  in  1  1 = write transaction, 0 = read transaction
- valid_i  in  1  transaction response valid, single-cycle per transaction
- data_o  out  8  ASCII byte to UART TX
- valid_o  out  1  data_o valid
- ready_i  in  1  UART TX accepts data_o this cycle
- full_o  out  1  FIFO holds DEPTH entries
- overflow_o  out  1  sticky: a response was dropped

Behaviour:
- Reset: rst_n low at a clk edge clears the following: FIFO pointers and count, frame engine to IDLE, byte index to 0, valid_o=0, overflow_o=0, full_o=0.
- data_o is combinational from state. It is 0x00 whenever valid_o=0.
- Reset asserted mid-frame abandons the frame immediately. No further bytes are emitted.
- Push condition: valid_i && (!rw_i || WRITE_ACK).
  - Entry stored = {is_ack = rw_i, rdata_i}. Data is ignored for ack entries.
  - If the FIFO is full at the edge, the entry is dropped and overflow_o is set. overflow_o is cleared only by reset.
  - Fullness is evaluated before any same-edge pop, so a push to a full FIFO is dropped even if a pop occurs on that edge.
- Push and pop on the same edge with the FIFO not full: count unchanged, both operations happen.
- full_o is registered and equals (count == DEPTH).
- Frame engine states:
  - IDLE: valid_o=0. If FIFO is not empty, pop the head into the frame register, set index=0 and go to SEND. Pop takes 1 edge.
  - SEND: valid_o=1, and data_o is selected by index:
    - index 0: 0x4D ('M').
    - Read frame, index 1..NIBBLES: hex of nibble [DATA_WIDTH-4(i-1)-1 -: 4]. Values 0-9 map to 0x30+n; values 10-15 map to 0x41+n-10 (uppercase).
    - Read frame, index NIBBLES+1: 0x0D. Index NIBBLES+2: 0x0A.
    - Ack frame: index 0 'M', index 1 0x0D, index 2 0x0A.
  - Index advances only on (valid_o && ready_i). data_o and valid_o are held stable while ready_i=0.
  - When the last byte (LF) is accepted:
    - FIFO not empty at that edge: pop the next entry on the same edge and reset index to 0. valid_o stays 1 with no idle cycle.
    - FIFO empty: go to IDLE with valid_o=0.
- Latency: valid_i high at edge N stores the entry. Engine pops at edge N+1. Preamble appears with valid_o=1 in the cycle after N+1.
- Frame length is NIBBLES+3 bytes for a read and 3 bytes for an ack.
- Widths:
  - Index counter is clog2(NIBBLES+3) bits.
  - FIFO count is clog2(DEPTH)+1 bits.
  - Pointers are clog2(DEPTH) bits and wrap naturally.
- A response arriving while the engine transmits is queued. It never corrupts the in-flight frame.

Test Plan:
- DATA_WIDTH=16, ready_i=1: read rdata_i=0xBEEF -> bytes 4D 42 45 45 46 0D 0A on consecutive cycles. valid_o falls after the LF cycle.
- Backpressure: same read with ready_i toggling 1,0,0,1,... -> the same 7 bytes in order. data_o is held stable while ready_i=0. No byte is duplicated or skipped.
- Three reads 0x0001, 0x00A0, 0xFFFF on consecutive cycles, ready_i=1 -> 21 bytes back-to-back with valid_o continuously high. The middle frame is 4D 30 30 41 30 0D 0A.
- DEPTH=4, ready_i=0: six reads -> the first read is in flight and four are queued. full_o=1 after the fifth read. The sixth read is dropped and overflow_o=1 (sticky). After releasing ready_i, exactly 5 frames are sent.
- WRITE_ACK=1: write, then read 0x1234 -> 4D 0D 0A followed by 4D 31 32 33 34 0D 0A. With WRITE_ACK=0 the same write is ignored.
- DATA_WIDTH=32: read 0xDEADBEEF -> 4D 44 45 41 44 42 45 45 46 0D 0A. Pull rst_n low after byte 3 -> valid_o=0 the next cycle, FIFO is empty, and overflow_o=0.
